// File: rtl/dropout_pkg.sv
// Shared definitions for the dropout round-robin scheduler: FSM states,
// LFSR constants and the statistics counter width.
package dropout_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    APPLY = 2'd1,
    HOLD  = 2'd2
  } state_t;

  localparam logic [15:0] LFSR_TAPS    = 16'hB400;
  localparam logic [15:0] DEFAULT_SEED = 16'hACE1;
  localparam int          STAT_W       = 16;

  // One Galois step, right-shifting; a nonzero state never maps to zero.
  function automatic logic [15:0] lfsr_next(input logic [15:0] l);
    return (l >> 1) ^ (l[0] ? LFSR_TAPS : 16'h0000);
  endfunction

endpackage

// File: rtl/dropout_rr_scheduler_if.sv
// Lane-request and result bus of the dropout scheduler.
//
// Handshake: a transfer happens on a rising clock edge where valid and
// ready are both high. On the request side the scheduler raises at most one
// req_ready bit, only for a lane whose req_valid is high. On the result side
// out_valid and the result fields stay stable until out_ready is seen.
interface dropout_rr_scheduler_if #(
  parameter int NUM_LANES = 8,
  parameter int DATA_W    = 8
);
  localparam int LANE_W = $clog2(NUM_LANES);

  logic [NUM_LANES-1:0]        req_valid;
  logic [NUM_LANES*DATA_W-1:0] req_data;
  logic [NUM_LANES-1:0]        req_ready;
  logic                        out_valid;
  logic                        out_ready;
  logic [DATA_W-1:0]           out_data;
  logic [LANE_W-1:0]           out_lane;
  logic                        out_dropped;

  // Lane/consumer side.
  modport master (
    output req_valid, req_data, out_ready,
    input  req_ready, out_valid, out_data, out_lane, out_dropped
  );

  // Scheduler side.
  modport slave (
    input  req_valid, req_data, out_ready,
    output req_ready, out_valid, out_data, out_lane, out_dropped
  );

endinterface

// File: rtl/dropout_lfsr16.sv
// 16-bit Galois LFSR with a step enable. rnd is the low byte of the value
// the register moves to on this step, so the caller can use it in the same
// cycle the step is taken.
module dropout_lfsr16
  import dropout_pkg::*;
#(
  parameter logic [15:0] SEED = DEFAULT_SEED
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       step,
  output logic [7:0] rnd
);

  logic [15:0] lfsr_q;
  logic [15:0] lfsr_d;

  assign lfsr_d = lfsr_next(lfsr_q);
  assign rnd    = lfsr_d[7:0];

  // LFSR register: reloads the seed on reset, advances only when stepped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_q <= SEED;
    end else if (step) begin
      lfsr_q <= lfsr_d;
    end
  end

endmodule

// File: rtl/dropout_rr_scheduler.sv
// Round-robin scheduler sharing one dropout datapath among NUM_LANES lanes.
// A lane is granted in IDLE, masked in APPLY and presented in HOLD until
// accepted. Optional build macro DROPOUT_SCALE_EN adds cfg_scale_shift, a
// saturating left shift applied to kept words.
module dropout_rr_scheduler
  import dropout_pkg::*;
#(
  parameter int          NUM_LANES = 8,
  parameter int          DATA_W    = 8,
  parameter logic [15:0] LFSR_SEED = DEFAULT_SEED
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ena,
  input  logic              cfg_train,
  input  logic [7:0]        cfg_keep_thresh,
`ifdef DROPOUT_SCALE_EN
  input  logic [1:0]        cfg_scale_shift,
`endif
  dropout_rr_scheduler_if.slave bus,
  output logic              busy,
  output logic [STAT_W-1:0] stat_drop_cnt,
  output state_t            dbg_state
);

  localparam int LANE_W = $clog2(NUM_LANES);

  state_t             state_q;
  state_t             state_d;
  logic [LANE_W-1:0]  rr_ptr;
  logic [LANE_W-1:0]  winner;
  logic [LANE_W-1:0]  cand;
  logic               found;
  logic               grant;
  logic [DATA_W-1:0]  data_q;
  logic [LANE_W-1:0]  lane_q;
  logic               lfsr_step;
  logic [7:0]         rnd;
  logic               keep;
  logic [DATA_W-1:0]  kept_data;

  // Search upward from the lane after the last winner, wrapping around;
  // the final candidate is the last winner itself.
  always_comb begin
    found  = 1'b0;
    winner = rr_ptr;
    cand   = rr_ptr;
    for (int i = 1; i <= NUM_LANES; i++) begin
      cand = rr_ptr + LANE_W'(i);
      if (!found && bus.req_valid[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
  end

  assign grant         = (state_q == IDLE) && ena && found;
  assign bus.req_ready = grant ? (NUM_LANES'(1) << winner) : '0;

  // FSM next state: one word per IDLE -> APPLY -> HOLD round trip.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (grant) state_d = APPLY;
      APPLY:   state_d = HOLD;
      HOLD:    if (bus.out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  assign busy      = (state_q != IDLE);
  assign dbg_state = state_q;

  // In pass-through mode the LFSR is frozen so the random sequence only
  // advances on words that are actually subject to dropout.
  assign lfsr_step = (state_q == APPLY) && cfg_train;
  assign keep      = !cfg_train || (rnd < cfg_keep_thresh);

  dropout_lfsr16 #(
    .SEED (LFSR_SEED)
  ) u_lfsr (
    .clk   (clk),
    .rst_n (rst_n),
    .step  (lfsr_step),
    .rnd   (rnd)
  );

`ifdef DROPOUT_SCALE_EN
  logic [DATA_W+2:0] scaled;

  // Scale a kept word; any bit shifted past the top saturates to all-ones.
  always_comb begin
    scaled    = {3'b000, data_q} << cfg_scale_shift;
    kept_data = (|scaled[DATA_W+2:DATA_W]) ? {DATA_W{1'b1}} : scaled[DATA_W-1:0];
  end
`else
  assign kept_data = data_q;
`endif

  // Datapath: latch the granted word, register the masked result and hold
  // it until accepted, and count dropped words without wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr          <= LANE_W'(NUM_LANES - 1);
      data_q          <= '0;
      lane_q          <= '0;
      bus.out_valid   <= 1'b0;
      bus.out_data    <= '0;
      bus.out_lane    <= '0;
      bus.out_dropped <= 1'b0;
      stat_drop_cnt   <= '0;
    end else begin
      if (grant) begin
        rr_ptr <= winner;
        data_q <= bus.req_data[int'(winner)*DATA_W +: DATA_W];
        lane_q <= winner;
      end
      if (state_q == APPLY) begin
        bus.out_valid   <= 1'b1;
        bus.out_data    <= keep ? kept_data : '0;
        bus.out_dropped <= !keep;
        bus.out_lane    <= lane_q;
        if (!keep && (stat_drop_cnt != {STAT_W{1'b1}})) begin
          stat_drop_cnt <= stat_drop_cnt + 1'b1;
        end
      end else if ((state_q == HOLD) && bus.out_ready) begin
        bus.out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_dropout_rr_scheduler.sv
// Self-checking bench for dropout_rr_scheduler: a vector table of first-word
// cases, hand-written multi-cycle sequences and a randomized run against a
// behavioural model (LFSR arithmetic + round-robin pick over a lane mask).
module tb_dropout_rr_scheduler;
  import dropout_pkg::*;

  localparam int NL = 8;
  localparam int DW = 8;
  localparam int LW = 3;
  localparam int W  = DW + LW + 1;

  typedef struct {
    bit         train;
    logic [7:0] thresh;
    int         lane;
    logic [7:0] data;
    logic [7:0] exp_data;
    bit         exp_drop;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ena = 1'b0;
  logic        cfg_train = 1'b0;
  logic [7:0]  cfg_keep_thresh = 8'h00;
`ifdef DROPOUT_SCALE_EN
  logic [1:0]  cfg_scale_shift = 2'd0;
`endif
  logic        busy;
  logic [15:0] stat_drop_cnt;
  state_t      dbg_state;

  int checks = 0;
  int errors = 0;

  logic [W-1:0] exp_q[$];
  int m_lfsr;
  int m_last;
  int m_drops;

  vec_t tbl[7];

  dropout_rr_scheduler_if #(.NUM_LANES(NL), .DATA_W(DW)) bus ();

  dropout_rr_scheduler #(
    .NUM_LANES (NL),
    .DATA_W    (DW),
    .LFSR_SEED (16'hACE1)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .ena             (ena),
    .cfg_train       (cfg_train),
    .cfg_keep_thresh (cfg_keep_thresh),
`ifdef DROPOUT_SCALE_EN
    .cfg_scale_shift (cfg_scale_shift),
`endif
    .bus             (bus),
    .busy            (busy),
    .stat_drop_cnt   (stat_drop_cnt),
    .dbg_state       (dbg_state)
  );

  // Clock and watchdog
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail_timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s: timed out waiting for DUT", name);
  endtask

  // Reference model
  task automatic model_reset();
    m_lfsr  = 'hACE1;
    m_last  = NL - 1;
    m_drops = 0;
    exp_q.delete();
  endtask

  function automatic int next_lane(input logic [NL-1:0] mask);
    for (int k = 1; k <= NL; k++) begin
      if (mask[(m_last + k) % NL]) begin
        m_last = (m_last + k) % NL;
        return m_last;
      end
    end
    return m_last;
  endfunction

  function automatic logic [W-1:0] model_apply(input logic [7:0] d, input int lane);
    bit keep_b;
    int v;
    if (cfg_train) begin
      m_lfsr = (m_lfsr >> 1) ^ (((m_lfsr % 2) == 1) ? 'hB400 : 0);
      keep_b = (m_lfsr % 256) < int'(cfg_keep_thresh);
    end else begin
      keep_b = 1'b1;
    end
    v = keep_b ? int'(d) : 0;
`ifdef DROPOUT_SCALE_EN
    if (keep_b) begin
      v = v * (1 << cfg_scale_shift);
      if (v > 255) v = 255;
    end
`endif
    if (!keep_b && m_drops < 65535) m_drops++;
    return {~keep_b, 3'(lane), 8'(v)};
  endfunction

  // Driver tasks
  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    ena = 1'b0;
    bus.req_valid = '0;
    bus.out_ready = 1'b0;
    cfg_train = 1'b0;
    cfg_keep_thresh = 8'h00;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    model_reset();
  endtask

  // Runs one word whose expectation is the last entry of exp_q: checks the
  // grant, the 2-edge latency, stability over `stall` HOLD cycles, then the
  // accepted result. Un-granted lanes keep requesting during the word.
  task automatic run_word(input logic [NL-1:0] mask, input logic [NL*DW-1:0] words,
                          input int stall, input bit kill_ena);
    logic [W-1:0] exp;
    logic [W-1:0] got;
    int lane;
    int n;
    exp = exp_q[$];
    lane = int'(exp[DW+LW-1:DW]);
    bus.req_valid = mask;
    bus.req_data = words;
    bus.out_ready = 1'b0;
    #1;
    n = 0;
    while (bus.req_ready == '0 && n < 20) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (bus.req_ready == '0) begin
      fail_timeout("grant_wait");
      void'(exp_q.pop_back());
      return;
    end
    check("grant_onehot", 32'(bus.req_ready), 32'(NL'(1) << lane));
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (n == 1) bus.req_valid = mask & ~(NL'(1) << lane);
      #1;
    end while (!bus.out_valid && n < 10);
    check("out_latency", n, 2);
    if (!bus.out_valid) begin
      fail_timeout("out_valid_wait");
      void'(exp_q.pop_front());
      return;
    end
    if (kill_ena) ena = 1'b0;
    for (int s = 0; s < stall; s++) begin
      check("hold_valid", 32'(bus.out_valid), 1);
      check("hold_word", 32'({bus.out_dropped, bus.out_lane, bus.out_data}), 32'(exp_q[0]));
      check("hold_no_grant", 32'(bus.req_ready), 0);
      check("hold_state", 32'(dbg_state), 32'(HOLD));
      @(negedge clk);
      #1;
    end
    check("busy_in_hold", 32'(busy), 1);
    bus.out_ready = 1'b1;
    got = {bus.out_dropped, bus.out_lane, bus.out_data};
    exp = exp_q.pop_front();
    check("out_word", 32'(got), 32'(exp));
    @(negedge clk);
    bus.out_ready = 1'b0;
    #1;
    check("accept_clears_valid", 32'(bus.out_valid), 0);
  endtask

  // Main test sequence
  initial begin
    logic [NL*DW-1:0] words;
    logic [NL-1:0]    mask;
    int               lane;
    int               k;

    tbl[0] = '{1'b1, 8'h80, 0, 8'h5A, 8'h5A, 1'b0};
    tbl[1] = '{1'b1, 8'h70, 0, 8'h5A, 8'h00, 1'b1};
    tbl[2] = '{1'b1, 8'h71, 3, 8'hC3, 8'hC3, 1'b0};
    tbl[3] = '{1'b1, 8'h00, 5, 8'hFF, 8'h00, 1'b1};
    tbl[4] = '{1'b1, 8'hFF, 7, 8'h81, 8'h81, 1'b0};
    tbl[5] = '{1'b0, 8'h00, 2, 8'h3C, 8'h3C, 1'b0};
    tbl[6] = '{1'b0, 8'h70, 6, 8'h11, 8'h11, 1'b0};

    bus.req_valid = '0;
    bus.req_data = '0;
    bus.out_ready = 1'b0;

    // Reset state, with requests present but ena low
    apply_reset();
    bus.req_valid = '1;
    #1;
    check("rst_out_valid", 32'(bus.out_valid), 0);
    check("rst_req_ready", 32'(bus.req_ready), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_stat", 32'(stat_drop_cnt), 0);
    check("rst_out_word", 32'({bus.out_dropped, bus.out_lane, bus.out_data}), 0);
    bus.req_valid = '0;

    // Vector table: each row is the first word after reset, so rnd = 0x70
    for (int i = 0; i < 7; i++) begin
      apply_reset();
      ena = 1'b1;
      cfg_train = tbl[i].train;
      cfg_keep_thresh = tbl[i].thresh;
      words = {$urandom, $urandom};
      words[tbl[i].lane*DW +: DW] = tbl[i].data;
      exp_q.push_back({tbl[i].exp_drop, 3'(tbl[i].lane), tbl[i].exp_data});
      run_word(NL'(1) << tbl[i].lane, words, i % 3, 1'b0);
      check("tbl_drop_cnt", 32'(stat_drop_cnt), 32'(tbl[i].exp_drop));
    end

    // Round-robin order with every lane requesting and out_ready high
    apply_reset();
    ena = 1'b1;
    bus.req_data = {$urandom, $urandom};
    bus.req_valid = '1;
    bus.out_ready = 1'b1;
    k = 0;
    for (int c = 0; c < 40 && k < 9; c++) begin
      #1;
      if (bus.req_ready != '0) begin
        check("rr_onehot", $countones(bus.req_ready), 1);
        check("rr_order", 32'(bus.req_ready), 32'(NL'(1) << (k % NL)));
        k++;
      end
      @(negedge clk);
    end
    check("rr_grant_count", k, 9);
    bus.req_valid = '0;
    bus.out_ready = 1'b0;

    // Pass-through: 10 words unchanged, LFSR must still be at the seed
    apply_reset();
    ena = 1'b1;
    for (int i = 0; i < 10; i++) begin
      mask = NL'($urandom_range(1, 255));
      words = {$urandom, $urandom};
      lane = next_lane(mask);
      exp_q.push_back({1'b0, 3'(lane), words[lane*DW +: DW]});
      void'(model_apply(words[lane*DW +: DW], lane));
      run_word(mask, words, 0, 1'b0);
    end
    check("pass_drop_cnt", 32'(stat_drop_cnt), 0);
    cfg_train = 1'b1;
    cfg_keep_thresh = 8'h70;
    bus.req_valid = '0;
    words = {$urandom, $urandom};
    lane = next_lane(NL'(1) << ((m_last + 1) % NL));
    void'(model_apply(words[lane*DW +: DW], lane));
    exp_q.push_back({1'b1, 3'(lane), 8'h00});
    run_word(NL'(1) << lane, words, 0, 1'b0);
    check("seed_held_drop_cnt", 32'(stat_drop_cnt), 1);

    // HOLD stall with another lane requesting, then ena dropped in HOLD
    apply_reset();
    ena = 1'b1;
    words = {$urandom, $urandom};
    lane = next_lane(8'h06);
    exp_q.push_back(model_apply(words[lane*DW +: DW], lane));
    run_word(8'h06, words, 5, 1'b0);
    lane = next_lane(8'h06);
    exp_q.push_back(model_apply(words[lane*DW +: DW], lane));
    run_word(8'h06, words, 2, 1'b1);
    for (int c = 0; c < 6; c++) begin
      check("ena_low_no_grant", 32'(bus.req_ready), 0);
      check("ena_low_idle", 32'(busy), 0);
      @(negedge clk);
      #1;
    end
    bus.req_valid = '0;

    // Reset in HOLD drops out_valid at once
    apply_reset();
    ena = 1'b1;
    cfg_train = 1'b1;
    cfg_keep_thresh = 8'h80;
    bus.req_data = 64'h5A;
    bus.req_valid = 8'h01;
    @(negedge clk);
    bus.req_valid = '0;
    @(negedge clk);
    #1;
    check("pre_rst_valid", 32'(bus.out_valid), 1);
    rst_n = 1'b0;
    #1;
    check("rst_hold_valid", 32'(bus.out_valid), 0);
    check("rst_hold_busy", 32'(busy), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Reset in APPLY: pointer returns to lane 0 priority
    apply_reset();
    ena = 1'b1;
    bus.req_valid = 8'h01;
    @(negedge clk);
    bus.req_valid = '0;
    #1;
    check("apply_busy", 32'(busy), 1);
    rst_n = 1'b0;
    #1;
    check("rst_apply_busy", 32'(busy), 0);
    check("rst_apply_valid", 32'(bus.out_valid), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    model_reset();
    words = {$urandom, $urandom};
    exp_q.push_back({1'b0, 3'd0, words[7:0]});
    run_word(8'h09, words, 0, 1'b0);

`ifdef DROPOUT_SCALE_EN
    // Saturating scale of kept words
    apply_reset();
    ena = 1'b1;
    cfg_scale_shift = 2'd2;
    words = '0;
    words[7:0] = 8'h30;
    words[15:8] = 8'h50;
    exp_q.push_back({1'b0, 3'd0, 8'hC0});
    run_word(8'h01, words, 0, 1'b0);
    exp_q.push_back({1'b0, 3'd1, 8'hFF});
    run_word(8'h02, words, 0, 1'b0);
    cfg_scale_shift = 2'd0;
    bus.req_valid = '0;
`endif

    // Randomized run against the reference model
    apply_reset();
    ena = 1'b1;
    for (int t = 0; t < 60; t++) begin
      mask = NL'($urandom_range(1, 255));
      words = {$urandom, $urandom};
      cfg_train = 1'($urandom_range(0, 1));
      cfg_keep_thresh = 8'($urandom_range(0, 255));
`ifdef DROPOUT_SCALE_EN
      cfg_scale_shift = 2'($urandom_range(0, 3));
`endif
      lane = next_lane(mask);
      exp_q.push_back(model_apply(words[lane*DW +: DW], lane));
      run_word(mask, words, $urandom_range(0, 3), 1'b0);
      check("rand_drop_cnt", 32'(stat_drop_cnt), 32'(m_drops));
    end
    bus.req_valid = '0;
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
